// File: rtl/instr_fetch_unit.sv
// Fetch stage of the multi-cycle MIPS core: owns the PC, runs a req/ack
// handshake with instruction memory and holds the fetched word for decode.
// The held low halfword and its sign/zero select drive the immediate extender.

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000  // must be word aligned
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchImm,
  input  logic        Jump,
  input  logic [25:0] JumpTarget,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic [31:0] PCOut,
  output logic [15:0] Imm,
  output logic        ImmSignExt
);

  typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [15:0] imm_q, imm_d;
  logic        imm_sign_ext_q, imm_sign_ext_d;

  logic        cap_sign_ext;
  logic [31:0] pc_out_inc;
  logic [31:0] jump_target;
  logic [31:0] branch_target;

  // Top two offset bits fall off the word-to-byte shift.
  logic unused_branch_imm_hi;
  assign unused_branch_imm_hi = ^BranchImm[31:30];

  // Redirect targets are relative to the held instruction, not the running PC.
  assign pc_out_inc    = pc_out_q + 32'd4;
  assign jump_target   = {pc_out_inc[31:28], JumpTarget, 2'b00};
  assign branch_target = pc_out_inc + {BranchImm[29:0], 2'b00};

  // Opcodes whose 16-bit immediate is sign-extended; everything else zero-extends.
  always_comb begin
    cap_sign_ext = 1'b0;
    case (IMemData[31:26])
      6'b001000,  // addi
      6'b001001,  // addiu
      6'b001010,  // slti
      6'b001011,  // sltiu
      6'b100011,  // lw
      6'b101011,  // sw
      6'b000100,  // beq
      6'b000101:  // bne
        cap_sign_ext = 1'b1;
      default: cap_sign_ext = 1'b0;
    endcase
  end

  // Next-state and datapath updates for the IDLE / REQ / HOLD fetch loop.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    imem_req_d     = imem_req_q;
    imem_addr_d    = imem_addr_q;
    instr_d        = instr_q;
    instr_valid_d  = instr_valid_q;
    pc_out_d       = pc_out_q;
    imm_d          = imm_q;
    imm_sign_ext_d = imm_sign_ext_q;

    unique case (state_q)
      StIdle: begin
        // Any stray ack from an abandoned request lands here and is ignored.
        imem_req_d  = 1'b1;
        imem_addr_d = pc_q;
        state_d     = StReq;
      end

      StReq: begin
        if (IMemAck) begin
          instr_d        = IMemData;
          imm_d          = IMemData[15:0];
          imm_sign_ext_d = cap_sign_ext;
          pc_out_d       = pc_q;
          pc_d           = pc_q + 32'd4;
          instr_valid_d  = 1'b1;
          imem_req_d     = 1'b0;
          state_d        = StHold;
        end
      end

      StHold: begin
        // Stall freezes everything; redirects only count on the consuming cycle.
        if (!Stall) begin
          instr_valid_d = 1'b0;
          imem_req_d    = 1'b1;
          state_d       = StReq;
          if (Jump) begin
            pc_d        = jump_target;
            imem_addr_d = jump_target;
          end else if (BranchTaken) begin
            pc_d        = branch_target;
            imem_addr_d = branch_target;
          end else begin
            imem_addr_d = pc_q;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State register; reset drops the request immediately.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q        <= StIdle;
      pc_q           <= RESET_PC;
      imem_req_q     <= 1'b0;
      imem_addr_q    <= RESET_PC;
      instr_q        <= 32'h0;
      instr_valid_q  <= 1'b0;
      pc_out_q       <= 32'h0;
      imm_q          <= 16'h0;
      imm_sign_ext_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      imem_req_q     <= imem_req_d;
      imem_addr_q    <= imem_addr_d;
      instr_q        <= instr_d;
      instr_valid_q  <= instr_valid_d;
      pc_out_q       <= pc_out_d;
      imm_q          <= imm_d;
      imm_sign_ext_q <= imm_sign_ext_d;
    end
  end

  assign IMemReq    = imem_req_q;
  assign IMemAddr   = imem_addr_q;
  assign Instr      = instr_q;
  assign InstrValid = instr_valid_q;
  assign PCOut      = pc_out_q;
  assign Imm        = imm_q;
  assign ImmSignExt = imm_sign_ext_q;

endmodule
